// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 command constants, the arbiter FSM state type,
// the init ROM depth and small helpers used by the LCD bus arbiter.
package lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] FUNC_SET   = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON    = 8'h0C;  // display on, cursor off
  localparam logic [7:0] ENTRY_INC  = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;
  localparam logic [7:0] DDRAM_L1   = 8'h80;
  localparam logic [7:0] DDRAM_L2   = 8'hC0;
  localparam logic [7:0] CGRAM_BASE = 8'h40;

  localparam int INIT_DEPTH = 4;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    INIT_LOAD = 3'd1,
    IDLE      = 3'd2,
    SETUP     = 3'd3,
    PULSE     = 3'd4,
    HOLD      = 3'd5
  } lcd_state_e;

  // Power-up init ROM, played in index order.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FUNC_SET;
      2'd1:    b = DISP_ON;
      2'd2:    b = ENTRY_INC;
      2'd3:    b = CLEAR;
      default: b = CLEAR;
    endcase
    return b;
  endfunction

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && ((d == CLEAR) || (d == HOME) || (d == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: free-running divider producing a one-Clk tick every TICK_DIV
// cycles; the tick is the time base for all LCD bus phases.
// Ports: Clk (clock), rst (async active-low reset), tick (registered pulse).
module lcd_tick_gen #(
  parameter int TICK_DIV = 2500
) (
  input  logic Clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Divider wrap and tick generation.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Divider state and registered tick.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns the HD44780 write-only bus. Plays the power-up init
// sequence, then grants the bus round-robin to N_REQ byte requesters, with a
// per-requester lock that keeps multi-byte bursts contiguous.
// Ports: Clk/rst; req/req_rs/req_data/req_lock from requesters; gnt/ack back
// to them; init_done/busy status; LCD_DATA/LCD_EN/LCD_RW/LCD_RS to the pins.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int TICK_DIV      = 2500,
  parameter int SHORT_WAIT    = 1,
  parameter int LONG_WAIT     = 32,
  parameter int POWERON_TICKS = 300
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rs,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic               init_done,
  output logic               busy,
  output logic [7:0]         LCD_DATA,
  output logic               LCD_EN,
  output logic               LCD_RW,
  output logic               LCD_RS
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = 16;
  localparam logic [WW-1:0] PON_LAST   = WW'(POWERON_TICKS - 1);
  localparam logic [WW-1:0] SHORT_W    = WW'(SHORT_WAIT);
  localparam logic [WW-1:0] LONG_W     = WW'(LONG_WAIT);
  localparam logic [LW-1:0] LAST_RESET = LW'(N_REQ - 1);
  localparam logic [1:0]    INIT_LAST  = 2'(INIT_DEPTH - 1);

  logic tick;

  lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk  (Clk),
    .rst  (rst),
    .tick (tick)
  );

  lcd_state_e       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [1:0]       idx_q, idx_d;
  logic [LW-1:0]    last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d, en_q, en_d;
  logic             init_done_q, init_done_d, busy_q, busy_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic [LW-1:0]    win;
  int               cand;

  // Winner selection: locked owner keeps the bus, else scan from last+1.
  always_comb begin
    win  = last_q;
    cand = 0;
    if (req_lock[last_q] && req[last_q]) begin
      win = last_q;
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        // Scanning backwards lets the nearest candidate overwrite farther ones.
        cand = (int'(last_q) + k) % N_REQ;
        if (req[cand]) begin
          win = LW'(cand);
        end else begin
          win = win;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_WAIT: state_d = (tick && (wait_q == PON_LAST)) ? INIT_LOAD : INIT_WAIT;
      INIT_LOAD: state_d = tick ? SETUP : INIT_LOAD;
      IDLE:      state_d = (init_done_q && (|req)) ? SETUP : IDLE;
      SETUP:     state_d = tick ? PULSE : SETUP;
      PULSE:     state_d = tick ? HOLD : PULSE;
      HOLD: begin
        if (tick && (wait_q <= WW'(1))) begin
          state_d = (init_done_q || (idx_q == INIT_LAST)) ? IDLE : INIT_LOAD;
        end else begin
          state_d = HOLD;
        end
      end
      default:   state_d = INIT_WAIT;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    wait_d      = wait_q;
    idx_d       = idx_q;
    last_d      = last_q;
    data_d      = data_q;
    rs_d        = rs_q;
    en_d        = en_q;
    init_done_d = init_done_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    case (state_q)
      INIT_WAIT: begin
        if (tick) wait_d = wait_q + WW'(1);
        else      wait_d = wait_q;
      end
      INIT_LOAD: begin
        data_d = init_byte(idx_q);
        rs_d   = 1'b0;
        gnt_d  = '0;
      end
      IDLE: begin
        if (init_done_q && (|req)) begin
          data_d = req_data[{win, 3'b000} +: 8];
          rs_d   = req_rs[win];
          gnt_d  = N_REQ'(1) << win;
          ack_d  = N_REQ'(1) << win;
          last_d = win;
        end else begin
          gnt_d  = '0;
        end
      end
      SETUP: begin
        if (tick) en_d = 1'b1;
        else      en_d = 1'b0;
      end
      PULSE: begin
        if (tick) begin
          en_d   = 1'b0;
          wait_d = is_long_cmd(rs_q, data_q) ? LONG_W : SHORT_W;
        end else begin
          en_d   = 1'b1;
        end
      end
      HOLD: begin
        if (tick && (wait_q <= WW'(1))) begin
          gnt_d = '0;
          if (!init_done_q) begin
            if (idx_q == INIT_LAST) init_done_d = 1'b1;
            else                    idx_d       = idx_q + 2'd1;
          end else begin
            idx_d = idx_q;
          end
        end else if (tick) begin
          wait_d = wait_q - WW'(1);
        end else begin
          wait_d = wait_q;
        end
      end
      default: begin
        en_d  = 1'b0;
        gnt_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_WAIT;
      wait_q      <= '0;
      idx_q       <= 2'd0;
      last_q      <= LAST_RESET;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      gnt_q       <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign LCD_DATA  = data_q;
  assign LCD_EN    = en_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: scoreboard bench for lcd_bus_arbiter. Expected bus
// bytes are queued when stimulus is driven and compared on each EN rise.
module tb_lcd_bus_arbiter;
  import lcd_pkg::*;

  localparam int TD = 4;

  logic        Clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000, req_rs = 3'b000, req_lock = 3'b000;
  logic [23:0] req_data = 24'h000000;
  logic [2:0]  gnt, ack;
  logic        init_done, busy, LCD_EN, LCD_RW, LCD_RS;
  logic [7:0]  LCD_DATA;

  lcd_bus_arbiter #(
    .N_REQ(3), .TICK_DIV(TD), .SHORT_WAIT(1), .LONG_WAIT(5), .POWERON_TICKS(2)
  ) dut (
    .Clk(Clk), .rst(rst), .req(req), .req_rs(req_rs), .req_data(req_data),
    .req_lock(req_lock), .gnt(gnt), .ack(ack), .init_done(init_done),
    .busy(busy), .LCD_DATA(LCD_DATA), .LCD_EN(LCD_EN), .LCD_RW(LCD_RW),
    .LCD_RS(LCD_RS)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [2:0] gnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic rs, input logic [7:0] d, input logic [2:0] g);
    exp_t e;
    e.rs = rs; e.data = d; e.gnt = g;
    sb_q.push_back(e);
  endtask

  // Bus monitor: pops the scoreboard on each EN rise, checks EN width and gaps.
  logic en_prev = 1'b0, prev_long = 1'b0;
  int   hi_cnt = 0, lo_cnt = 0, last_gap = 0;
  always @(negedge Clk) begin
    if (!rst) begin
      en_prev   <= 1'b0;
      prev_long <= 1'b0;
      hi_cnt    <= 0;
      lo_cnt    <= 0;
    end else begin
      en_prev <= LCD_EN;
      if (LCD_EN && !en_prev) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_byte", {23'd0, LCD_RS, LCD_DATA}, 32'hFFFF_FFFF);
        end else begin
          check("bus_byte", {23'd0, LCD_RS, LCD_DATA}, {23'd0, sb_q[0].rs, sb_q[0].data});
          check("bus_gnt", {29'd0, gnt}, {29'd0, sb_q[0].gnt});
          check("bus_rw", {31'd0, LCD_RW}, 32'd0);
          if (prev_long) check("long_gap_min", (lo_cnt >= 5 * TD) ? 32'd1 : 32'd0, 32'd1);
          prev_long <= is_long_cmd(sb_q[0].rs, sb_q[0].data);
          void'(sb_q.pop_front());
        end
        last_gap <= lo_cnt;
        hi_cnt   <= 1;
      end else if (LCD_EN) begin
        hi_cnt <= hi_cnt + 1;
      end else if (en_prev) begin
        check("en_width", hi_cnt, TD);
        lo_cnt <= 1;
      end else begin
        lo_cnt <= lo_cnt + 1;
      end
    end
  end

  task automatic wait_ack(input int i);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!ack[i] && n < 3000);
    if (!ack[i]) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_any_ack();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((ack == 3'b000) && n < 3000);
    if (ack == 3'b000) check("ack_any_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((busy || sb_q.size() != 0) && n < 5000);
    if (busy || sb_q.size() != 0) check("idle_timeout", sb_q.size(), 32'd0);
  endtask

  // Present a byte on requester i, queue its expectation, return at its ack.
  task automatic send(input int i, input logic rs, input logic [7:0] d, input logic lk);
    push_exp(rs, d, 3'(1 << i));
    req_rs[i]         = rs;
    req_data[8*i +: 8] = d;
    req_lock[i]       = lk;
    req[i]            = 1'b1;
    wait_ack(i);
  endtask

  task automatic push_init();
    push_exp(1'b0, 8'h38, 3'b000);
    push_exp(1'b0, 8'h0C, 3'b000);
    push_exp(1'b0, 8'h06, 3'b000);
    push_exp(1'b0, 8'h01, 3'b000);
  endtask

  initial begin
    int n, pre, cnt;
    logic [2:0] rr_exp [4];

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst_en", {31'd0, LCD_EN}, 32'd0);
    check("rst_rs", {31'd0, LCD_RS}, 32'd0);
    check("rst_data", {24'd0, LCD_DATA}, 32'd0);
    check("rst_gnt_ack", {26'd0, gnt, ack}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // Init sequence
    push_init();
    rst = 1'b1;
    n = 0;
    while (!init_done && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    check("init_done", {31'd0, init_done}, 32'd1);
    check("init_busy", {31'd0, busy}, 32'd0);
    check("init_bytes_out", sb_q.size(), 32'd0);

    // Single write and return to idle after the short wait
    send(1, 1'b1, 8'h41, 1'b0);
    req[1] = 1'b0;
    @(negedge Clk);
    check("ack_one_cycle", {29'd0, ack}, 32'd0);
    n = 0;
    while (!LCD_EN && n < 100) begin @(negedge Clk); n++; end
    while (LCD_EN && n < 200) begin @(negedge Clk); n++; end
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; @(negedge Clk); end
    check("idle_after_short", cnt, TD);

    // Long wait after clear with RS=0; data 0x01 with RS=1 gets the short wait
    send(2, 1'b0, CLEAR, 1'b0);
    send(2, 1'b1, 8'h42, 1'b0);
    req[2] = 1'b0;
    wait_idle();
    check("gap_after_clear", (last_gap >= 5 * TD) ? 32'd1 : 32'd0, 32'd1);
    send(2, 1'b1, 8'h01, 1'b0);
    send(2, 1'b1, 8'h43, 1'b0);
    req[2] = 1'b0;
    wait_idle();
    check("gap_after_data01", (last_gap < 5 * TD) ? 32'd1 : 32'd0, 32'd1);

    // Round-robin with all three requesting; last owner was 2
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) push_exp(1'b1, 8'h10 + 8'(rr_exp[k] >> 1), rr_exp[k]);
    req_rs = 3'b111; req_lock = 3'b000;
    req_data = {8'h12, 8'h11, 8'h10};
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_any_ack();
      check("rr_ack", {29'd0, ack}, {29'd0, rr_exp[k]});
    end
    req = 3'b000;
    wait_idle();

    // Locked burst on requester 2 while requester 0 keeps asking
    push_exp(1'b0, DDRAM_L2, 3'b100);
    for (int b = 0; b < 16; b++) push_exp(1'b1, 8'h60 + 8'(b), 3'b100);
    push_exp(1'b1, 8'h55, 3'b001);
    req_rs = 3'b001; req_lock = 3'b100;
    req_data = {DDRAM_L2, 8'h00, 8'h55};
    req = 3'b101;
    for (int b = 0; b < 17; b++) begin
      wait_ack(2);
      check("burst_ack", {29'd0, ack}, 32'd4);
      if (b < 16) begin
        req_rs[2] = 1'b1;
        req_data[23:16] = 8'h60 + 8'(b);
      end else begin
        req[2] = 1'b0;
        req_lock[2] = 1'b0;
      end
    end
    wait_ack(0);
    check("after_burst_ack", {29'd0, ack}, 32'd1);
    req[0] = 1'b0;
    wait_idle();

    // Reset in the middle of an EN pulse
    send(0, 1'b1, 8'hAA, 1'b0);
    req[0] = 1'b0;
    n = 0;
    while (!LCD_EN && n < 200) begin @(negedge Clk); n++; end
    check("pulse_reached", {31'd0, LCD_EN}, 32'd1);
    @(posedge Clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_en", {31'd0, LCD_EN}, 32'd0);
    check("mid_rst_gnt", {29'd0, gnt}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    sb_q.delete();
    push_init();
    push_exp(1'b1, 8'h5A, 3'b010);
    req_rs[1] = 1'b1; req_data[15:8] = 8'h5A; req_lock = 3'b000;
    req[1] = 1'b1;
    repeat (3) @(negedge Clk);
    rst = 1'b1;
    n = 0; pre = 0;
    while (!ack[1] && n < 5000) begin
      @(negedge Clk);
      n++;
      if ((ack != 3'b000) && !init_done) pre++;
    end
    check("replay_ack_seen", {31'd0, ack[1]}, 32'd1);
    check("no_ack_pre_init", pre, 32'd0);
    check("init_done_at_ack", {31'd0, init_done}, 32'd1);
    req[1] = 1'b0;
    wait_idle();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the HD44780 character LCD bus: runs the power-up init sequence, then shares the bus between N_REQ byte-level requesters, e.g. the game-state text writer, the time/score writer and the CGRAM font loader.
- Arbitration is round-robin, with a per-requester lock so a multi-byte burst is never split; a locked burst is, for example, a DDRAM address followed by 16 characters.
- Generates RS/RW/EN/DATA timing from a tick divider and inserts the long wait after clear/home commands.
- Sits between the display-content generators and the LCD pins on the board top level.

Parameters:
- N_REQ, 3, number of requesters.
- TICK_DIV, 2500, Clk cycles per bus tick (50 us at 50 MHz).
- SHORT_WAIT, 1, ticks held after an ordinary command or data write.
- LONG_WAIT, 32, ticks held after clear (0x01) or home (0x02/0x03) with RS=0.
- POWERON_TICKS, 300, ticks waited after reset before the first init byte.

Ports:
- Clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester byte request, level, held until ack
- req_rs  in  N_REQ  RS for each requester's byte (0 = command, 1 = data)
- req_data  in  8*N_REQ  byte per requester; requester i uses bits [8i+7:8i]
- req_lock  in  N_REQ  keep grant for the next byte of a burst
- gnt  out  N_REQ  one-hot, current bus owner
- ack  out  N_REQ  one-Clk pulse when the byte is captured
- init_done  out  1  init sequence complete
- busy  out  1  bus transaction or init in progress
- LCD_DATA  out  8  data bus (write-only)
- LCD_EN  out  1  enable strobe
- LCD_RW  out  1  tied 0
- LCD_RS  out  1  register select

Behaviour:
- Reset values (rst=0, asynchronous): LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, gnt=0, ack=0, init_done=0, busy=1. The FSM enters INIT_WAIT and the tick divider clears.
- Tick generation:
  - tick is a one-Clk pulse every TICK_DIV cycles from a free-running counter.
  - Every FSM step except arbitration advances only on tick.
- FSM states: INIT_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD.
- INIT_WAIT: count POWERON_TICKS ticks, then go to INIT_LOAD.
- INIT_LOAD:
  - Loads the next init byte, in order 0x38, 0x0C, 0x06, 0x01, with RS=0.
  - Then goes to SETUP.
  - After the 4th byte's HOLD completes: init_done=1 (sticky until reset) and the FSM goes to IDLE.
- IDLE: busy=0. If any req bit is high, in that same Clk cycle:
  - choose the winner w;
  - latch req_data[w] and req_rs[w] into the output registers;
  - gnt=onehot(w), ack[w]=1 for exactly one cycle, busy=1, go to SETUP.
- Winner selection:
  - If req_lock[last] && req[last], then w = last.
  - Otherwise w is the first set req bit scanning last+1, last+2, ... modulo N_REQ.
  - last resets to N_REQ-1, so requester 0 wins first.
  - req_lock is ignored while the owner's req is low.
- SETUP: EN=0 with DATA/RS stable. On tick go to PULSE.
- PULSE: EN=1. On tick set EN=0, load the wait counter, go to HOLD.
  - Wait counter = LONG_WAIT if RS=0 and data is 0x01, 0x02 or 0x03.
  - Otherwise wait counter = SHORT_WAIT.
- HOLD: decrement the wait counter on each tick. At 0, go to IDLE (or INIT_LOAD during init). gnt clears on HOLD exit.
- Timing: EN high for exactly TICK_DIV Clk cycles. DATA/RS stable from SETUP entry until HOLD exit.
- Requests before init_done are not acked.
- A req dropped after ack has no effect on the byte in flight. A req dropped before ack is simply not granted.
- Simultaneous requests: exactly one ack per grant. Losers wait, with no starvation (bounded by N_REQ transactions when lock is not abused).
- Reset mid-transaction: EN drops immediately (async), and the full init sequence replays.

Decomposition:
- Shared package lcd_pkg holds:
  - HD44780 constants: FUNC_SET 0x38, DISP_ON 0x0C, ENTRY_INC 0x06, CLEAR 0x01, HOME 0x02, DDRAM_L1 0x80, DDRAM_L2 0xC0, CGRAM_BASE 0x40;
  - the FSM state enum;
  - the init ROM depth constant (4).
- One sub-module, lcd_tick_gen, containing the divider and tick pulse.

Test Plan (bench uses TICK_DIV=4, POWERON_TICKS=2, LONG_WAIT=5):
- Init: release rst, no req -> four EN pulses carrying 0x38, 0x0C, 0x06, 0x01 with RS=0. A gap of 5 ticks follows the 0x01. Then init_done=1 and busy=0.
- Single write: req[1]=1, rs=1, data=0x41 -> ack[1] pulses 1 cycle. One EN pulse 4 Clk wide with LCD_DATA=0x41, RS=1. Back in IDLE after SHORT_WAIT.
- Round-robin: req=3'b111 held, lock=0 -> grant order 0,1,2,0.
- Lock burst:
  - Requester 2 sends 0xC0 followed by 16 data bytes with lock=1.
  - req[0] is asserted throughout.
  - Expected: all 17 bytes go out consecutively on requester 2, then requester 0 is granted.
- Long wait: requester sends 0x01 with RS=0 -> next EN rise no earlier than 5 ticks after EN fall. Sending 0x01 with RS=1 instead uses the 1-tick wait.
- Reset mid-PULSE: drop rst while EN=1 -> EN=0 and gnt=0 the same cycle. After release, the init sequence replays and ack is suppressed until init_done.
